// File: rtl/moltiplicatore_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier (N x N -> 2N) with a start/ready/done handshake.
// Define MOLT_EARLY_EXIT_EN to end RUN as soon as the remaining multiplier bits are all zero.
module moltiplicatore_seq_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] ris
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [2*N-1:0]   mcand, acc, acc_sum;
  logic [N-1:0]     mplr;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign acc_sum = acc + (mplr[0] ? mcand : '0);

`ifdef MOLT_EARLY_EXIT_EN
  // once no set bits remain above mplr[0] further iterations cannot change acc
  assign last = (cnt == CNT_W'(N - 1)) || ((mplr >> 1) == '0);
`else
  assign last = (cnt == CNT_W'(N - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      ris   <= '0;
      done  <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        mcand <= {{N{1'b0}}, a};
        mplr  <= b;
        acc   <= '0;
        cnt   <= '0;
      end
    end else begin
      acc   <= acc_sum;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CNT_W'(1);
      done  <= last;
      if (last) ris <= acc_sum;
    end
  end

endmodule

// File: tb/tb_moltiplicatore_seq_ctrl.sv
// Self-checking bench for moltiplicatore_seq_ctrl: vector table plus handshake corner cases,
// results checked against a scoreboard of expected product and completion cycle.
module tb_moltiplicatore_seq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a, b;
  logic         ready, busy, done;
  logic [2*N-1:0] ris;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp;
  } vec_t;

  typedef struct {
    logic [2*N-1:0] ris;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  logic done_q = 1'b0;

  moltiplicatore_seq_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .ris   (ris)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latency(input logic [N-1:0] bv);
`ifdef MOLT_EARLY_EXIT_EN
    int l = 1;
    for (int i = 0; i < N; i++) if (bv[i]) l = i + 1;
    return l;
`else
    return N;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // caller must be away from clock edges; start is accepted at the next posedge
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic [2*N-1:0] ex);
    int guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!ready) begin
      assertions++;
      failures++;
      $display("[TB] FAIL ready_timeout: ready stuck low, expected 1");
    end
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk); #1;
    sb.push_back('{ex, cyc + latency(bv)});
    start = 1'b0;
  endtask

  task automatic waitDone();
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(negedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // monitor: every done must match the oldest expected result, in the expected cycle
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("done_width", {31'b0, done & done_q}, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL spurious_done: done=1 with ris=%0d, expected no done", ris);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("ris", {16'b0, ris}, {16'b0, e.ris});
          checkOutput("latency", cyc, e.cyc);
        end
      end
    end
    done_q <= done;
  end

  initial begin
    vecs[0] = '{8'd0,   8'd0,   16'd0};
    vecs[1] = '{8'd2,   8'd1,   16'd2};
    vecs[2] = '{8'd3,   8'd2,   16'd6};
    vecs[3] = '{8'd255, 8'd255, 16'hFE01};
    vecs[4] = '{8'd5,   8'd7,   16'd35};
    vecs[5] = '{8'd7,   8'd6,   16'd42};
    vecs[6] = '{8'd1,   8'd128, 16'd128};
    vecs[7] = '{8'd128, 8'd1,   16'd128};
    vecs[8] = '{8'd170, 8'd85,  16'd14450};
    vecs[9] = '{8'd200, 8'd0,   16'd0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {31'b0, ready}, 32'd1);
    checkOutput("reset_busy",  {31'b0, busy},  32'd0);
    checkOutput("reset_done",  {31'b0, done},  32'd0);
    checkOutput("reset_ris",   {16'b0, ris},   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp);
      waitDone();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("ris_hold", {16'b0, ris}, {16'b0, vecs[i].exp});
      checkOutput("idle_ready", {31'b0, ready}, 32'd1);
    end

    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom_range(0, 255));
      rb = N'($urandom_range(0, 255));
      applyStimulus(ra, rb, 16'(ra * rb));
      waitDone();
    end

    // start while busy must be ignored
    applyStimulus(8'd11, 8'd13, 16'd143);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_mid_op",  {31'b0, busy},  32'd1);
    checkOutput("ready_mid_op", {31'b0, ready}, 32'd0);
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();
    repeat (12) @(posedge clk);
    #1;
    checkOutput("ignored_start_ris", {16'b0, ris}, 32'd143);

    // back-to-back: second start issued in the done cycle
    applyStimulus(8'd3, 8'd3, 16'd9);
    waitDone();
    checkOutput("b2b_done_visible", {31'b0, done}, 32'd1);
    applyStimulus(8'd5, 8'd7, 16'd35);
    waitDone();

    // asynchronous reset in the middle of an operation
    applyStimulus(8'd3, 8'd200, 16'd600);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_ris",   {16'b0, ris},   32'd0);
    checkOutput("midreset_done",  {31'b0, done},  32'd0);
    checkOutput("midreset_ready", {31'b0, ready}, 32'd1);
    checkOutput("midreset_busy",  {31'b0, busy},  32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    #1;
    checkOutput("post_reset_ris", {16'b0, ris}, 32'd0);
    applyStimulus(8'd6, 8'd7, 16'd42);
    waitDone();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
